// File: rtl/pps_time_keeper_if.sv
// Time-keeper bus: time-set request towards the keeper, time of day and
// lock status back from it.
interface pps_time_keeper_if #(
  parameter int unsigned CW = 28
);
  logic          set_time;
  logic [4:0]    set_hh;
  logic [5:0]    set_mm;
  logic [5:0]    set_ss;
  logic [4:0]    hh;
  logic [5:0]    mm;
  logic [5:0]    ss;
  logic          sec_tick;
  logic          locked;
  logic          holdover;
  logic [CW-1:0] period;

  modport master (
    output set_time, set_hh, set_mm, set_ss,
    input  hh, mm, ss, sec_tick, locked, holdover, period
  );

  modport slave (
    input  set_time, set_hh, set_mm, set_ss,
    output hh, mm, ss, sec_tick, locked, holdover, period
  );
endinterface

// File: rtl/pps_time_keeper.sv
// GPS PPS time keeper: timestamps PPS edges against the free-running tick
// counter, locks to PPS, keeps hh:mm:ss and emits one sec_tick per second,
// flywheeling on the last measured period when PPS disappears.
module pps_time_keeper #(
  parameter int unsigned CW         = 28,
  parameter int unsigned NOM_TICKS  = 100_000_000,
  parameter int unsigned TOL        = 1_000,
  parameter int unsigned LOCK_COUNT = 3,
  parameter int unsigned MAX_HOLD   = 3600
) (
  input  logic          clock,
  input  logic          rst,
  input  logic [CW-1:0] counter,
  input  logic          pps,
  pps_time_keeper_if.slave tk
);
  localparam int unsigned   GW        = $clog2(LOCK_COUNT + 1);
  localparam int unsigned   HW        = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] NOM_P     = CW'(NOM_TICKS);
  localparam logic [CW-1:0] WIN_LO    = CW'(NOM_TICKS - TOL);
  localparam logic [CW-1:0] WIN_HI    = CW'(NOM_TICKS + TOL);
  localparam logic [CW-1:0] TOL_M1    = CW'(TOL - 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_COUNT - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {HUNT, ACQUIRE, LOCKED, HOLDOVER} state_t;

  state_t        state_q, state_d;
  logic          pps_s1_q, pps_s1_d, pps_s2_q, pps_s2_d, pps_s3_q, pps_s3_d;
  logic          pps_evt_q, pps_evt_d;
  logic [CW-1:0] last_cap_q, last_cap_d;
  logic [GW-1:0] good_cnt_q, good_cnt_d;
  logic [CW-1:0] local_cnt_q, local_cnt_d;
  logic [HW-1:0] hold_secs_q, hold_secs_d;
  logic [CW-1:0] period_q, period_d;
  logic          sec_tick_q, tick_d;
  logic [4:0]    hh_q, hh_d;
  logic [5:0]    mm_q, mm_d, ss_q, ss_d;
  logic [CW-1:0] delta;
  logic          delta_good;
  logic          set_ok;

  // PPS synchroniser and registered rising-edge detect (pin rise -> evt in 3 clocks)
  always_comb begin
    pps_s1_d  = pps;
    pps_s2_d  = pps_s1_q;
    pps_s3_d  = pps_s2_q;
    pps_evt_d = pps_s2_q & ~pps_s3_q;
  end

  // Lock FSM: next state, capture/period bookkeeping and second-boundary decision
  always_comb begin
    state_d     = state_q;
    last_cap_d  = last_cap_q;
    good_cnt_d  = good_cnt_q;
    local_cnt_d = local_cnt_q + CW'(1);
    hold_secs_d = hold_secs_q;
    period_d    = period_q;
    tick_d      = 1'b0;
    delta       = counter - last_cap_q;
    delta_good  = (delta >= WIN_LO) && (delta <= WIN_HI);
    unique case (state_q)
      HUNT: begin
        if (pps_evt_q) begin
          last_cap_d = counter;
          good_cnt_d = '0;
          state_d    = ACQUIRE;
        end
      end
      ACQUIRE: begin
        if (pps_evt_q) begin
          last_cap_d = counter;
          if (delta_good) begin
            good_cnt_d = good_cnt_q + GW'(1);
            if (good_cnt_q == GOOD_LAST) begin
              state_d     = LOCKED;
              period_d    = delta;
              tick_d      = 1'b1;
              local_cnt_d = '0;
            end
          end else begin
            good_cnt_d = '0;
          end
        end
      end
      LOCKED: begin
        // An out-of-window edge is a glitch: it neither ticks nor moves
        // the capture reference, and the loss timeout keeps running.
        if (pps_evt_q && delta_good) begin
          tick_d      = 1'b1;
          period_d    = delta;
          last_cap_d  = counter;
          local_cnt_d = '0;
        end else if (local_cnt_q == period_q + TOL_M1) begin
          state_d     = HOLDOVER;
          tick_d      = 1'b1;
          local_cnt_d = '0;
          hold_secs_d = '0;
        end
      end
      HOLDOVER: begin
        if (pps_evt_q) begin
          // Late in the flywheel second: PPS is the boundary we owe.
          // Early: that second was already ticked, just realign.
          state_d     = LOCKED;
          last_cap_d  = counter;
          local_cnt_d = '0;
          tick_d      = (local_cnt_q >= (period_q >> 1));
        end else if (local_cnt_q == period_q - CW'(1)) begin
          tick_d      = 1'b1;
          local_cnt_d = '0;
          hold_secs_d = hold_secs_q + HW'(1);
          if (hold_secs_q == HOLD_LAST) begin
            state_d = HUNT;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // Time of day: a valid load wins over a coincident second tick
  always_comb begin
    hh_d   = hh_q;
    mm_d   = mm_q;
    ss_d   = ss_q;
    set_ok = (tk.set_hh <= 5'd23) && (tk.set_mm <= 6'd59) && (tk.set_ss <= 6'd59);
    if (tk.set_time && set_ok) begin
      hh_d = tk.set_hh;
      mm_d = tk.set_mm;
      ss_d = tk.set_ss;
    end else if (tick_d) begin
      if (ss_q == 6'd59) begin
        ss_d = '0;
        if (mm_q == 6'd59) begin
          mm_d = '0;
          if (hh_q == 5'd23) begin
            hh_d = '0;
          end else begin
            hh_d = hh_q + 5'd1;
          end
        end else begin
          mm_d = mm_q + 6'd1;
        end
      end else begin
        ss_d = ss_q + 6'd1;
      end
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= HUNT;
      pps_s1_q    <= 1'b0;
      pps_s2_q    <= 1'b0;
      pps_s3_q    <= 1'b0;
      pps_evt_q   <= 1'b0;
      last_cap_q  <= '0;
      good_cnt_q  <= '0;
      local_cnt_q <= '0;
      hold_secs_q <= '0;
      period_q    <= NOM_P;
      sec_tick_q  <= 1'b0;
      hh_q        <= '0;
      mm_q        <= '0;
      ss_q        <= '0;
    end else begin
      state_q     <= state_d;
      pps_s1_q    <= pps_s1_d;
      pps_s2_q    <= pps_s2_d;
      pps_s3_q    <= pps_s3_d;
      pps_evt_q   <= pps_evt_d;
      last_cap_q  <= last_cap_d;
      good_cnt_q  <= good_cnt_d;
      local_cnt_q <= local_cnt_d;
      hold_secs_q <= hold_secs_d;
      period_q    <= period_d;
      sec_tick_q  <= tick_d;
      hh_q        <= hh_d;
      mm_q        <= mm_d;
      ss_q        <= ss_d;
    end
  end

  assign tk.hh       = hh_q;
  assign tk.mm       = mm_q;
  assign tk.ss       = ss_q;
  assign tk.sec_tick = sec_tick_q;
  assign tk.locked   = (state_q == LOCKED);
  assign tk.holdover = (state_q == HOLDOVER);
  assign tk.period   = period_q;
endmodule

// File: tb/tb_pps_time_keeper.sv
// Testbench for pps_time_keeper: directed scenarios plus randomized PPS
// traffic, checked every cycle against a behavioural model.
module tb_pps_time_keeper;
  localparam int unsigned CW    = 28;
  localparam int unsigned NOM   = 100;
  localparam int unsigned TOL   = 5;
  localparam int unsigned LOCKN = 3;
  localparam int unsigned MAXH  = 4;
  localparam longint      MASK  = (longint'(1) << CW) - 1;

  localparam int MD_HUNT = 0, MD_ACQ = 1, MD_LOCK = 2, MD_HOLD = 3;

  logic          clock = 1'b0;
  logic          rst;
  logic          pps;
  logic [CW-1:0] counter;

  pps_time_keeper_if #(.CW(CW)) tk ();

  pps_time_keeper #(
    .CW(CW), .NOM_TICKS(NOM), .TOL(TOL), .LOCK_COUNT(LOCKN), .MAX_HOLD(MAXH)
  ) dut (
    .clock(clock), .rst(rst), .counter(counter), .pps(pps), .tk(tk)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int ticks_seen = 0;
  bit rnd_on = 0;

  // Behavioural model state (values after the most recent clock edge)
  int       m_mode;
  longint   m_cap, m_loc, m_period;
  int       m_good, m_hold, m_hh, m_mm, m_ss;
  bit       m_tick;
  bit [3:0] hist;  // pin as sampled at the last four edges, [0] newest

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock edge of the specification's rules, applied to current inputs
  task automatic model_step();
    bit     evt, good, tk_n;
    longint delta, loc_n;
    if (rst) begin
      m_mode = MD_HUNT; m_cap = 0; m_loc = 0; m_period = NOM;
      m_good = 0; m_hold = 0; m_hh = 0; m_mm = 0; m_ss = 0;
      m_tick = 0; hist = '0;
      return;
    end
    evt   = hist[2] && !hist[3];
    delta = (longint'(counter) - m_cap) & MASK;
    good  = (delta >= NOM - TOL) && (delta <= NOM + TOL);
    tk_n  = 0;
    loc_n = (m_loc + 1) & MASK;
    case (m_mode)
      MD_HUNT: if (evt) begin m_cap = counter; m_good = 0; m_mode = MD_ACQ; end
      MD_ACQ: if (evt) begin
        m_cap = counter;
        if (!good) m_good = 0;
        else begin
          m_good++;
          if (m_good == LOCKN) begin m_mode = MD_LOCK; m_period = delta; tk_n = 1; loc_n = 0; end
        end
      end
      MD_LOCK: begin
        if (evt && good) begin tk_n = 1; m_period = delta; m_cap = counter; loc_n = 0; end
        else if (m_loc == m_period + TOL - 1) begin
          m_mode = MD_HOLD; tk_n = 1; loc_n = 0; m_hold = 0;
        end
      end
      default: begin
        if (evt) begin
          m_mode = MD_LOCK; m_cap = counter; loc_n = 0; tk_n = (m_loc >= m_period / 2);
        end else if (m_loc == m_period - 1) begin
          tk_n = 1; loc_n = 0; m_hold++;
          if (m_hold >= MAXH) m_mode = MD_HUNT;
        end
      end
    endcase
    if (tk.set_time && tk.set_hh <= 23 && tk.set_mm <= 59 && tk.set_ss <= 59) begin
      m_hh = tk.set_hh; m_mm = tk.set_mm; m_ss = tk.set_ss;
    end else if (tk_n) begin
      int secs;
      secs = (m_hh * 3600 + m_mm * 60 + m_ss + 1) % 86400;
      m_hh = secs / 3600; m_mm = (secs / 60) % 60; m_ss = secs % 60;
    end
    m_tick = tk_n;
    m_loc  = loc_n;
    hist   = {hist[2:0], pps};
  endtask

  task automatic compare();
    check("hh", tk.hh, m_hh);
    check("mm", tk.mm, m_mm);
    check("ss", tk.ss, m_ss);
    check("sec_tick", tk.sec_tick, m_tick);
    check("locked", tk.locked, m_mode == MD_LOCK);
    check("holdover", tk.holdover, m_mode == MD_HOLD);
    check("period", tk.period, m_period);
  endtask

  task automatic step();
    model_step();
    @(posedge clock);
    #1;
    compare();
    if (tk.sec_tick) ticks_seen++;
    counter = counter + 1'b1;
  endtask

  task automatic rand_set();
    if (rnd_on && $urandom_range(0, 39) == 0) begin
      tk.set_time = 1'b1;
      tk.set_hh   = 5'($urandom_range(0, 26));
      tk.set_mm   = 6'($urandom_range(0, 62));
      tk.set_ss   = 6'($urandom_range(0, 62));
    end else begin
      tk.set_time = 1'b0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin rand_set(); step(); end
  endtask

  // Pin high for w cycles, then low until gap cycles after the rise
  task automatic pulse(input int w, input int gap);
    pps = 1'b1;
    for (int i = 0; i < gap; i++) begin
      if (i == w) pps = 1'b0;
      rand_set();
      step();
    end
    pps = 1'b0;
  endtask

  task automatic wait_hold_loc(input longint target, input int budget);
    bit reached;
    reached = 0;
    for (int i = 0; i < budget; i++) begin
      if (m_mode == MD_HOLD && m_loc == target) begin reached = 1; break; end
      step();
    end
    check("wait_holdover_point", reached, 1);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) step();
    rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pps = 1'b0; counter = '0;
    tk.set_time = 1'b0; tk.set_hh = '0; tk.set_mm = '0; tk.set_ss = '0;
    do_reset(3);
    check("rst_hh", tk.hh, 0);
    check("rst_ss", tk.ss, 0);
    check("rst_locked", tk.locked, 0);
    check("rst_holdover", tk.holdover, 0);
    check("rst_period", tk.period, 100);
    check("rst_tick", tk.sec_tick, 0);

    // Lock at 100 ticks: locks on 4th PPS, three seconds counted by the 6th
    for (int i = 0; i < 6; i++) pulse(5, 100);
    check("lock_locked", tk.locked, 1);
    check("lock_period", tk.period, 100);
    check("lock_ss", tk.ss, 3);

    // Glitch 30 clocks after a good edge is ignored
    pulse(5, 30);
    ticks_seen = 0;
    pulse(5, 70);
    check("glitch_no_tick", ticks_seen, 0);
    pulse(5, 100);
    check("glitch_period", tk.period, 100);
    check("glitch_ss", tk.ss, 5);
    check("glitch_locked", tk.locked, 1);

    // Counter wrap: delta measured across 2^CW
    rst = 1'b1; counter = 28'hFFF_FFD8; step(); step(); rst = 1'b0;
    for (int i = 0; i < 6; i++) pulse(5, 102);
    check("wrap_locked", tk.locked, 1);
    check("wrap_period", tk.period, 102);

    // PPS loss: holdover, four flywheel seconds, then hunt
    for (int i = 0; i < 3; i++) pulse(5, 100);
    check("loss_pre_period", tk.period, 100);
    ticks_seen = 0;
    run(150);
    check("loss_holdover", tk.holdover, 1);
    run(450);
    check("loss_ticks", ticks_seen, 5);
    check("loss_hunt_locked", tk.locked, 0);
    check("loss_hunt_holdover", tk.holdover, 0);

    // Re-acquire from holdover: late edge ticks, early edge realigns silently
    for (int i = 0; i < 5; i++) pulse(5, 100);
    wait_hold_loc(67, 400);
    ticks_seen = 0;
    pulse(5, 100);
    check("reacq_late_ticks", ticks_seen, 1);
    check("reacq_late_locked", tk.locked, 1);
    wait_hold_loc(7, 400);
    ticks_seen = 0;
    pulse(5, 100);
    check("reacq_early_ticks", ticks_seen, 0);
    check("reacq_early_locked", tk.locked, 1);

    // Rollover and set_time
    tk.set_time = 1'b1; tk.set_hh = 5'd23; tk.set_mm = 6'd59; tk.set_ss = 6'd59;
    step();
    tk.set_time = 1'b0;
    check("set_hh", tk.hh, 23);
    pulse(5, 100);
    check("roll_hh", tk.hh, 0);
    check("roll_mm", tk.mm, 0);
    check("roll_ss", tk.ss, 0);
    tk.set_time = 1'b1; tk.set_hh = 5'd24; tk.set_mm = 6'd0; tk.set_ss = 6'd0;
    step();
    tk.set_time = 1'b0;
    check("bad_set_hh", tk.hh, 0);
    check("bad_set_ss", tk.ss, 0);
    pps = 1'b1;
    step(); step(); step();
    tk.set_time = 1'b1; tk.set_hh = 5'd12; tk.set_mm = 6'd34; tk.set_ss = 6'd56;
    step();
    tk.set_time = 1'b0;
    check("coll_tick", tk.sec_tick, 1);
    check("coll_hh", tk.hh, 12);
    check("coll_mm", tk.mm, 34);
    check("coll_ss", tk.ss, 56);
    step();
    pps = 1'b0;
    run(95);

    // Randomized traffic
    rnd_on = 1;
    for (int k = 0; k < 50; k++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (k == 25) do_reset(1);
      if (kind == 0)      pulse($urandom_range(1, 10), $urandom_range(15, 60));
      else if (kind == 1) run($urandom_range(150, 450));
      else if (kind == 2) pulse($urandom_range(1, 10),
                                ($urandom_range(0, 1) == 0) ? $urandom_range(80, 94)
                                                            : $urandom_range(106, 120));
      else                pulse($urandom_range(1, 10), $urandom_range(95, 105));
    end
    rnd_on = 0;
    run(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
